memory_arbiter: RTL and testbench

//  Shares one RAM port between the pipeline's instruction fetch port (i*) and data port (d*).

---
 rtl/memory_arbiter_if.sv | 36 +++
 rtl/memory_arbiter.sv | 151 +++++++++++++++
 tb/tb_memory_arbiter.sv | 296 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/memory_arbiter_if.sv
// memory_arbiter_if: bundles the instruction port, data port and RAM port
// signals that pass through the memory arbiter.
// The slave modport is the arbiter's view.
// The master modport is the surrounding environment's view (datapath plus RAM).
interface memory_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              iREN;
  logic [ADDR_W-1:0] iaddr;
  logic              ihit;
  logic [DATA_W-1:0] iload;
  logic              dREN;
  logic              dWEN;
  logic [ADDR_W-1:0] daddr;
  logic [DATA_W-1:0] dstore;
  logic              dhit;
  logic [DATA_W-1:0] dload;
  logic              ramREN;
  logic              ramWEN;
  logic [ADDR_W-1:0] ramaddr;
  logic [DATA_W-1:0] ramstore;
  logic [DATA_W-1:0] ramload;
  logic [1:0]        ramstate;
  logic              ram_err;

  modport slave (
    input  iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    output ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );

  modport master (
    output iREN, iaddr, dREN, dWEN, daddr, dstore, ramload, ramstate,
    input  ihit, iload, dhit, dload, ramREN, ramWEN, ramaddr, ramstore, ram_err
  );
endinterface

// File: rtl/memory_arbiter.sv
// memory_arbiter: shares one RAM port between the instruction fetch port
// and the data port. A registered grant FSM (IDLE/IGNT/DGNT) runs one
// access at a time and waits on ramstate for the RAM to finish.
// Optional feature macro: MEMARB_FAIR_EN. When it is defined, a streak
// counter stops the data port from starving instruction fetch.
// When it is undefined, data requests always win in IDLE.
module memory_arbiter #(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int DSTREAK_MAX = 4
) (
  input  logic CLK,
  input  logic nRST,
  memory_arbiter_if.slave bus
);

  typedef enum logic [1:0] {IDLE, IGNT, DGNT} state_t;

  localparam logic [1:0] RAM_ACCESS = 2'd2;
  localparam logic [1:0] RAM_ERROR  = 2'd3;

  if (DSTREAK_MAX < 1) begin : gBadCfg
    $error("memory_arbiter: DSTREAK_MAX must be at least 1");
  end

  state_t            state_q, state_d;
  logic              ramErr_q, ramErr_d;
  logic              dreq;
  logic              ramRen, ramWen, iHit, dHit;
  logic [ADDR_W-1:0] ramAddr;
  logic [DATA_W-1:0] ramStore, iLoad, dLoad;

`ifdef MEMARB_FAIR_EN
  localparam int StreakW = $clog2(DSTREAK_MAX + 1);
  localparam logic [StreakW-1:0] StreakMax = StreakW'(DSTREAK_MAX);
  logic [StreakW-1:0] streak_q, streak_d;
`endif

  // Next-state and output decode.
  // RAM controls follow the granted port combinationally.
  // An abort is checked before completion, so a dropped request never produces a hit.
  always_comb begin
    state_d  = state_q;
    ramErr_d = ramErr_q;
    ramRen   = 1'b0;
    ramWen   = 1'b0;
    ramAddr  = '0;
    ramStore = '0;
    iHit     = 1'b0;
    dHit     = 1'b0;
    iLoad    = '0;
    dLoad    = '0;
    dreq     = bus.dREN | bus.dWEN;
`ifdef MEMARB_FAIR_EN
    streak_d = streak_q;
`endif
    case (state_q)
      IDLE: begin
`ifdef MEMARB_FAIR_EN
        if ((streak_q == StreakMax) && bus.iREN) begin
          state_d  = IGNT;
          streak_d = '0;
        end else if (dreq) begin
          state_d = DGNT;
          if (bus.iREN) begin
            streak_d = (streak_q == StreakMax) ? streak_q : streak_q + 1'b1;
          end else begin
            streak_d = '0;
          end
        end else if (bus.iREN) begin
          state_d  = IGNT;
          streak_d = '0;
        end
`else
        if (dreq) begin
          state_d = DGNT;
        end else if (bus.iREN) begin
          state_d = IGNT;
        end
`endif
      end
      IGNT: begin
        ramRen  = bus.iREN;
        ramAddr = bus.iaddr;
        if (bus.ramstate == RAM_ERROR) begin
          ramErr_d = 1'b1;
        end
        if (!bus.iREN) begin
          state_d = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          iHit    = 1'b1;
          iLoad   = bus.ramload;
          state_d = IDLE;
        end
      end
      DGNT: begin
        ramWen   = bus.dWEN;
        ramRen   = bus.dREN & ~bus.dWEN;
        ramAddr  = bus.daddr;
        ramStore = bus.dstore;
        if (bus.ramstate == RAM_ERROR) begin
          ramErr_d = 1'b1;
        end
        if (!dreq) begin
          state_d = IDLE;
        end else if (bus.ramstate == RAM_ACCESS) begin
          dHit    = 1'b1;
          dLoad   = bus.ramload;
          state_d = IDLE;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Grant state and sticky error flag.
  // Reset drops any grant at once, and every output decodes to zero in IDLE.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q  <= IDLE;
      ramErr_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      ramErr_q <= ramErr_d;
    end
  end

`ifdef MEMARB_FAIR_EN
  // Count of consecutive data grants taken while instruction fetch was waiting.
  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      streak_q <= '0;
    end else begin
      streak_q <= streak_d;
    end
  end
`endif

  assign bus.ramREN   = ramRen;
  assign bus.ramWEN   = ramWen;
  assign bus.ramaddr  = ramAddr;
  assign bus.ramstore = ramStore;
  assign bus.ihit     = iHit;
  assign bus.iload    = iLoad;
  assign bus.dhit     = dHit;
  assign bus.dload    = dLoad;
  assign bus.ram_err  = ramErr_q;

endmodule

// File: tb/tb_memory_arbiter.sv
// tb_memory_arbiter: directed test of memory_arbiter.
// The expected grant order depends on whether MEMARB_FAIR_EN is defined.
module tb_memory_arbiter;

  localparam logic [1:0] FREE   = 2'd0;
  localparam logic [1:0] BUSY   = 2'd1;
  localparam logic [1:0] ACCESS = 2'd2;
  localparam logic [1:0] ERROR  = 2'd3;

  logic CLK;
  logic nRST;
  int   total;
  int   bad;

  memory_arbiter_if #(.ADDR_W(32), .DATA_W(32)) bus ();

  memory_arbiter #(.ADDR_W(32), .DATA_W(32), .DSTREAK_MAX(2)) dut (
    .CLK  (CLK),
    .nRST (nRST),
    .bus  (bus.slave)
  );

  // Free-running clock with a 10 ns period
  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic clearInputs();
    bus.iREN     = 1'b0;
    bus.iaddr    = '0;
    bus.dREN     = 1'b0;
    bus.dWEN     = 1'b0;
    bus.daddr    = '0;
    bus.dstore   = '0;
    bus.ramload  = '0;
    bus.ramstate = FREE;
  endtask

  task automatic test_reset();
    clearInputs();
    nRST = 1'b0;
    repeat (2) tick();
    total++;
    if ({bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.ram_err} !== 5'b0) begin
      bad++;
      $display("[TB] FAIL reset_ctrl: got %b want 00000", {bus.ramREN, bus.ramWEN, bus.ihit, bus.dhit, bus.ram_err});
    end
    total++;
    if ({bus.ramaddr, bus.ramstore, bus.iload, bus.dload} !== 128'b0) begin
      bad++;
      $display("[TB] FAIL reset_bus: got %h want 0", {bus.ramaddr, bus.ramstore, bus.iload, bus.dload});
    end
    nRST = 1'b1;
  endtask

  task automatic test_reset_mid_dgnt();
    tick();
    bus.dWEN = 1'b1; bus.daddr = 32'h10; bus.dstore = 32'hAA; bus.ramstate = BUSY;
    tick();
    total++;
    if (bus.ramWEN !== 1'b1) begin
      bad++;
      $display("[TB] FAIL rst_mid_wen_before: got %b want 1", bus.ramWEN);
    end
    #2 nRST = 1'b0;
    #1;
    total++;
    if (bus.ramWEN !== 1'b0 || bus.ramaddr !== 32'h0) begin
      bad++;
      $display("[TB] FAIL rst_mid_async: got wen=%b addr=%h want wen=0 addr=0", bus.ramWEN, bus.ramaddr);
    end
    tick();
    bus.ramstate = ACCESS;
    nRST = 1'b1;
    #1;
    total++;
    if (bus.dhit !== 1'b0 || bus.ramWEN !== 1'b0) begin
      bad++;
      $display("[TB] FAIL rst_mid_after: got dhit=%b wen=%b want 0 0", bus.dhit, bus.ramWEN);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_i_read();
    bus.iREN = 1'b1; bus.iaddr = 32'h40; bus.ramstate = BUSY;
    #1;
    total++;
    if (bus.ramREN !== 1'b0) begin
      bad++;
      $display("[TB] FAIL iread_idle_ren: got %b want 0", bus.ramREN);
    end
    for (int k = 0; k < 3; k++) begin
      tick();
      total++;
      if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h40 || bus.ihit !== 1'b0) begin
        bad++;
        $display("[TB] FAIL iread_busy%0d: got ren=%b addr=%h ihit=%b want 1 00000040 0", k, bus.ramREN, bus.ramaddr, bus.ihit);
      end
    end
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'h2402000A;
    #1;
    total++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h2402000A || bus.dhit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL iread_access: got ihit=%b iload=%h dhit=%b want 1 2402000a 0", bus.ihit, bus.iload, bus.dhit);
    end
    tick();
    #1;
    total++;
    if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b0) begin
      bad++;
      $display("[TB] FAIL iread_idle_after: got ihit=%b ren=%b want 0 0", bus.ihit, bus.ramREN);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_contention();
    bus.iREN = 1'b1; bus.iaddr = 32'h44; bus.dREN = 1'b1; bus.daddr = 32'h80; bus.ramstate = BUSY;
    tick();
    total++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h80 || bus.ramWEN !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cont_dgnt: got ren=%b addr=%h wen=%b want 1 00000080 0", bus.ramREN, bus.ramaddr, bus.ramWEN);
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h11;
    #1;
    total++;
    if (bus.dhit !== 1'b1 || bus.dload !== 32'h11 || bus.ihit !== 1'b0 || bus.iload !== 32'h0) begin
      bad++;
      $display("[TB] FAIL cont_dhit: got dhit=%b dload=%h ihit=%b iload=%h want 1 00000011 0 0", bus.dhit, bus.dload, bus.ihit, bus.iload);
    end
    tick();
    bus.dREN = 1'b0; bus.ramstate = BUSY;
    #1;
    total++;
    if (bus.ramREN !== 1'b0 || bus.dhit !== 1'b0 || bus.ihit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL cont_idle: got ren=%b dhit=%b ihit=%b want 0 0 0", bus.ramREN, bus.dhit, bus.ihit);
    end
    tick();
    total++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h44) begin
      bad++;
      $display("[TB] FAIL cont_ignt: got ren=%b addr=%h want 1 00000044", bus.ramREN, bus.ramaddr);
    end
    bus.ramstate = ACCESS; bus.ramload = 32'h22;
    #1;
    total++;
    if (bus.ihit !== 1'b1 || bus.iload !== 32'h22 || bus.dhit !== 1'b0 || bus.dload !== 32'h0) begin
      bad++;
      $display("[TB] FAIL cont_ihit: got ihit=%b iload=%h dhit=%b dload=%h want 1 00000022 0 0", bus.ihit, bus.iload, bus.dhit, bus.dload);
    end
    tick();
    clearInputs();
    tick();
  endtask

  task automatic test_write_abort();
    bus.dREN = 1'b1; bus.dWEN = 1'b1; bus.daddr = 32'h100; bus.dstore = 32'hDEADBEEF; bus.ramstate = BUSY;
    tick();
    total++;
    if (bus.ramWEN !== 1'b1 || bus.ramREN !== 1'b0 || bus.ramstore !== 32'hDEADBEEF || bus.ramaddr !== 32'h100) begin
      bad++;
      $display("[TB] FAIL wr_prio: got wen=%b ren=%b store=%h addr=%h want 1 0 deadbeef 00000100", bus.ramWEN, bus.ramREN, bus.ramstore, bus.ramaddr);
    end
    bus.ramstate = ACCESS;
    #1;
    total++;
    if (bus.dhit !== 1'b1) begin
      bad++;
      $display("[TB] FAIL wr_dhit: got %b want 1", bus.dhit);
    end
    tick();
    clearInputs();
    bus.iREN = 1'b1; bus.iaddr = 32'h200; bus.ramstate = BUSY;
    tick();
    total++;
    if (bus.ramREN !== 1'b1 || bus.ramaddr !== 32'h200) begin
      bad++;
      $display("[TB] FAIL abort_grant: got ren=%b addr=%h want 1 00000200", bus.ramREN, bus.ramaddr);
    end
    tick();
    bus.iREN = 1'b0;
    #1;
    total++;
    if (bus.ramREN !== 1'b0 || bus.ihit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_drop: got ren=%b ihit=%b want 0 0", bus.ramREN, bus.ihit);
    end
    tick();
    bus.iREN = 1'b1; bus.ramstate = ACCESS;
    #1;
    total++;
    if (bus.ihit !== 1'b0 || bus.ramREN !== 1'b0) begin
      bad++;
      $display("[TB] FAIL abort_idle: got ihit=%b ren=%b want 0 0", bus.ihit, bus.ramREN);
    end
    clearInputs();
    tick();
  endtask

  task automatic test_error();
    bus.dREN = 1'b1; bus.daddr = 32'h300; bus.ramstate = BUSY;
    tick();
    bus.ramstate = ERROR;
    #1;
    total++;
    if (bus.dhit !== 1'b0 || bus.ramREN !== 1'b1 || bus.ram_err !== 1'b0) begin
      bad++;
      $display("[TB] FAIL err_cycle: got dhit=%b ren=%b err=%b want 0 1 0", bus.dhit, bus.ramREN, bus.ram_err);
    end
    tick();
    bus.ramstate = ACCESS; bus.ramload = 32'h55;
    #1;
    total++;
    if (bus.ram_err !== 1'b1 || bus.dhit !== 1'b1 || bus.dload !== 32'h55) begin
      bad++;
      $display("[TB] FAIL err_access: got err=%b dhit=%b dload=%h want 1 1 00000055", bus.ram_err, bus.dhit, bus.dload);
    end
    tick();
    clearInputs();
    repeat (2) tick();
    total++;
    if (bus.ram_err !== 1'b1 || bus.dhit !== 1'b0) begin
      bad++;
      $display("[TB] FAIL err_sticky: got err=%b dhit=%b want 1 0", bus.ram_err, bus.dhit);
    end
  endtask

  task automatic test_grant_order();
    logic expectD [6];
`ifdef MEMARB_FAIR_EN
    expectD = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
`else
    expectD = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
`endif
    bus.iREN = 1'b1; bus.iaddr = 32'h400; bus.dREN = 1'b1; bus.daddr = 32'h500; bus.ramstate = BUSY;
    for (int n = 0; n < 6; n++) begin
      #1;
      total++;
      if (bus.ramREN !== 1'b0) begin
        bad++;
        $display("[TB] FAIL order_idle%0d: got ren=%b want 0", n, bus.ramREN);
      end
      tick();
      total++;
      if (bus.ramaddr !== (expectD[n] ? 32'h500 : 32'h400)) begin
        bad++;
        $display("[TB] FAIL order_grant%0d: got addr=%h want %h", n, bus.ramaddr, (expectD[n] ? 32'h500 : 32'h400));
      end
      bus.ramstate = ACCESS;
      #1;
      total++;
      if (bus.dhit !== expectD[n] || bus.ihit !== !expectD[n]) begin
        bad++;
        $display("[TB] FAIL order_hit%0d: got dhit=%b ihit=%b want %b %b", n, bus.dhit, bus.ihit, expectD[n], !expectD[n]);
      end
      tick();
      bus.ramstate = BUSY;
    end
    clearInputs();
    tick();
  endtask

  // Run every scenario in sequence and print the summary
  initial begin
    total = 0;
    bad   = 0;
    test_reset();
    test_reset_mid_dgnt();
    test_i_read();
    test_contention();
    test_write_abort();
    test_error();
    test_grant_order();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Simulation time bound
  initial begin
    #100000;
    $display("[TB] FAIL timeout: got no finish want finish");
    $fatal(1, "[TB] timeout");
  end

endmodule
